// File: rtl/l1route_shift_sequencer.sv
// l1route_shift_sequencer
// Upstream control stage of the column-wise multi-source L1 route, which has
// five stride-group QSN shifters. It stores per-layer, per-source shift-factor
// vectors. On start it replays them in order:
//   (layer 0, src 0), (layer 0, src 1), (layer 1, src 0), ... (N-1, src 1).
// For each issue it drives the route source select and the shift factors,
// pulses a read strobe to the message memories, and emits a valid delayed to
// match the route pipeline, tagged with layer and source.
//
// Ports
//   sys_clk, rst      clock, synchronous active-high reset
//   cfg_we_i          table write strobe (honoured in IDLE only)
//   cfg_layer_i       table write layer
//   cfg_src_i         table write source (0=in0, 1=in1)
//   cfg_shift_i       shift vector; stride k at [k*BW +: BW]
//   cfg_err_o         1-cycle pulse on a rejected cfg write or start
//   start_i           run request
//   layer_num_i       layers to run, legal range 1..LAYER_NUM
//   stall_i           downstream not ready; freezes issue
//   busy_o            high from start acceptance until done_o
//   done_o            1-cycle pulse when the run is complete
//   rd_en_o           issue strobe to the message memories
//   sw_in_src_o       route source select
//   shift_factor_o    route shift factors, packed like cfg_shift_i
//   out_valid_o       rd_en_o delayed by ROUTE_LATENCY cycles
//   out_layer_o       layer tag aligned with out_valid_o
//   out_src_o         source tag aligned with out_valid_o
module l1route_shift_sequencer #(
  parameter int unsigned STRIDE_UNIT_SIZE = 51,
  parameter int unsigned STRIDE_WIDTH     = 5,
  parameter int unsigned LAYER_NUM        = 4,
  parameter int unsigned ROUTE_LATENCY    = 2,
  localparam int unsigned BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE - 1),
  localparam int unsigned LAYER_ID_WIDTH  = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1,
  localparam int unsigned VEC_W           = STRIDE_WIDTH * BITWIDTH_SHIFT_FACTOR
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      cfg_we_i,
  input  logic [LAYER_ID_WIDTH-1:0] cfg_layer_i,
  input  logic                      cfg_src_i,
  input  logic [VEC_W-1:0]          cfg_shift_i,
  output logic                      cfg_err_o,
  input  logic                      start_i,
  input  logic [LAYER_ID_WIDTH:0]   layer_num_i,
  input  logic                      stall_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      rd_en_o,
  output logic                      sw_in_src_o,
  output logic [VEC_W-1:0]          shift_factor_o,
  output logic                      out_valid_o,
  output logic [LAYER_ID_WIDTH-1:0] out_layer_o,
  output logic                      out_src_o
);

  localparam int unsigned BW          = BITWIDTH_SHIFT_FACTOR;
  localparam int unsigned LW          = LAYER_ID_WIDTH;
  localparam int unsigned NUM_W       = LAYER_ID_WIDTH + 1;
  localparam int unsigned IDX_W       = LAYER_ID_WIDTH + 1;
  localparam int unsigned TABLE_DEPTH = 2 * LAYER_NUM;
  localparam int unsigned DRAIN_W     = $clog2(ROUTE_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_W-1:0]     num_q, num_d;
  logic [LW-1:0]        layer_q, layer_d;
  logic                 src_q, src_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [LW-1:0]        tag_layer_q, tag_layer_d;
  logic [VEC_W-1:0]     table_q [TABLE_DEPTH];

  logic                 err_d, busy_d, done_d, rd_en_d, sw_src_d;
  logic [VEC_W-1:0]     shift_d;

  logic                 fields_ok, layer_ok, cfg_ok, cfg_bad;
  logic                 num_ok, start_ok, start_bad, last_issue;
  logic [IDX_W-1:0]     cfg_idx, rd_idx;
  logic [VEC_W-1:0]     first_vec;

  logic [ROUTE_LATENCY-1:0] vld_pipe;
  logic [LW-1:0]            lay_pipe [ROUTE_LATENCY];
  logic [ROUTE_LATENCY-1:0] src_pipe;

  // Request qualification
  always_comb begin
    fields_ok = 1'b1;
    for (int k = 0; k < int'(STRIDE_WIDTH); k++) begin
      if ({1'b0, cfg_shift_i[k*BW +: BW]} >= (BW+1)'(STRIDE_UNIT_SIZE)) fields_ok = 1'b0;
    end
    layer_ok   = {1'b0, cfg_layer_i} < IDX_W'(LAYER_NUM);
    cfg_ok     = cfg_we_i && !busy_o && fields_ok && layer_ok;
    cfg_bad    = cfg_we_i && !cfg_ok;
    num_ok     = (layer_num_i != '0) && (layer_num_i <= NUM_W'(LAYER_NUM));
    start_ok   = start_i && (state_q == S_IDLE) && num_ok;
    start_bad  = start_i && (state_q == S_IDLE) && !num_ok;
    cfg_idx    = {cfg_layer_i, cfg_src_i};
    rd_idx     = {layer_q, src_q};
    // A write committed on the start edge must be seen by the first issue
    first_vec  = (cfg_ok && cfg_idx == '0) ? cfg_shift_i : table_q[0];
    last_issue = src_q && ({1'b0, layer_q} == (num_q - NUM_W'(1)));
  end

  // Next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    layer_d     = layer_q;
    src_d       = src_q;
    drain_d     = drain_q;
    tag_layer_d = tag_layer_q;
    rd_en_d     = 1'b0;
    sw_src_d    = sw_in_src_o;
    shift_d     = shift_factor_o;
    done_d      = 1'b0;
    err_d       = cfg_bad || start_bad;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_ISSUE;
          num_d   = layer_num_i;
          layer_d = '0;
          src_d   = 1'b0;
          // The acceptance edge is also the first issue slot
          if (!stall_i) begin
            rd_en_d     = 1'b1;
            sw_src_d    = 1'b0;
            shift_d     = first_vec;
            tag_layer_d = '0;
            src_d       = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!stall_i) begin
          rd_en_d     = 1'b1;
          sw_src_d    = src_q;
          shift_d     = table_q[rd_idx];
          tag_layer_d = layer_q;
          if (last_issue) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else if (src_q) begin
            src_d   = 1'b0;
            layer_d = layer_q + LW'(1);
          end else begin
            src_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Wait until the last issue has left the route pipeline
        if (drain_q == DRAIN_W'(ROUTE_LATENCY)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and outputs
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      num_q          <= '0;
      layer_q        <= '0;
      src_q          <= 1'b0;
      drain_q        <= '0;
      tag_layer_q    <= '0;
      cfg_err_o      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      sw_in_src_o    <= 1'b0;
      shift_factor_o <= '0;
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      layer_q        <= layer_d;
      src_q          <= src_d;
      drain_q        <= drain_d;
      tag_layer_q    <= tag_layer_d;
      cfg_err_o      <= err_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      rd_en_o        <= rd_en_d;
      sw_in_src_o    <= sw_src_d;
      shift_factor_o <= shift_d;
    end
  end

  // Shift-factor table
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TABLE_DEPTH); i++) table_q[i] <= '0;
    end else if (cfg_ok) begin
      table_q[cfg_idx] <= cfg_shift_i;
    end
  end

  // Route-latency delay pipe; advances every cycle, stalls included
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      vld_pipe <= '0;
      src_pipe <= '0;
      for (int i = 0; i < int'(ROUTE_LATENCY); i++) lay_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= rd_en_o;
      lay_pipe[0] <= tag_layer_q;
      src_pipe[0] <= sw_in_src_o;
      for (int i = 1; i < int'(ROUTE_LATENCY); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lay_pipe[i] <= lay_pipe[i-1];
        src_pipe[i] <= src_pipe[i-1];
      end
    end
  end

  assign out_valid_o = vld_pipe[ROUTE_LATENCY-1];
  assign out_layer_o = lay_pipe[ROUTE_LATENCY-1];
  assign out_src_o   = src_pipe[ROUTE_LATENCY-1];

endmodule

// File: tb/tb_l1route_shift_sequencer.sv
// Bench for l1route_shift_sequencer: directed scenarios plus randomized runs
// checked against a schedule-level model of issue, valid and done timing.
`timescale 1ns/1ps
module tb_l1route_shift_sequencer;

  localparam int unsigned BW    = 6;
  localparam int unsigned VEC_W = 30;
  localparam int unsigned LW    = 2;
  localparam int          LAT   = 2;
  localparam int          PATN  = 64;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             cfg_we_i;
  logic [LW-1:0]    cfg_layer_i;
  logic             cfg_src_i;
  logic [VEC_W-1:0] cfg_shift_i;
  logic             cfg_err_o;
  logic             start_i;
  logic [LW:0]      layer_num_i;
  logic             stall_i;
  logic             busy_o;
  logic             done_o;
  logic             rd_en_o;
  logic             sw_in_src_o;
  logic [VEC_W-1:0] shift_factor_o;
  logic             out_valid_o;
  logic [LW-1:0]    out_layer_o;
  logic             out_src_o;

  l1route_shift_sequencer dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .cfg_we_i       (cfg_we_i),
    .cfg_layer_i    (cfg_layer_i),
    .cfg_src_i      (cfg_src_i),
    .cfg_shift_i    (cfg_shift_i),
    .cfg_err_o      (cfg_err_o),
    .start_i        (start_i),
    .layer_num_i    (layer_num_i),
    .stall_i        (stall_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rd_en_o        (rd_en_o),
    .sw_in_src_o    (sw_in_src_o),
    .shift_factor_o (shift_factor_o),
    .out_valid_o    (out_valid_o),
    .out_layer_o    (out_layer_o),
    .out_src_o      (out_src_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Model state: table in issue order (entry k = layer k/2, src k%2)
  logic [VEC_W-1:0] model_tab [8];
  logic [VEC_W-1:0] last_vec;
  logic             last_src;
  int               stall_pat [PATN];
  int               total_cnt = 0;
  int               pass_cnt  = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] mk_vec(input int a, input int b, input int c,
                                              input int d, input int e);
    logic [VEC_W-1:0] v;
    v[0*BW +: BW] = BW'(a);
    v[1*BW +: BW] = BW'(b);
    v[2*BW +: BW] = BW'(c);
    v[3*BW +: BW] = BW'(d);
    v[4*BW +: BW] = BW'(e);
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    return mk_vec(int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
                  int'($urandom_range(0, 50)), int'($urandom_range(0, 50)),
                  int'($urandom_range(0, 50)));
  endfunction

  function automatic bit vec_legal(input logic [VEC_W-1:0] v);
    for (int k = 0; k < 5; k++) if (int'(v[k*BW +: BW]) > 50) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void clear_stalls();
    for (int i = 0; i < PATN; i++) stall_pat[i] = 0;
  endfunction

  task automatic cfg_write(input int l, input bit s, input logic [VEC_W-1:0] v);
    bit exp_err;
    exp_err     = !vec_legal(v);
    cfg_we_i    = 1'b1;
    cfg_layer_i = LW'(l);
    cfg_src_i   = s;
    cfg_shift_i = v;
    tick();
    cfg_we_i = 1'b0;
    if (!exp_err) model_tab[l*2 + int'(s)] = v;
    total_cnt++;
    if (cfg_err_o !== exp_err)
      $display("FAIL cfg_err l=%0d s=%0d got %b exp %b", l, s, cfg_err_o, exp_err);
    else pass_cnt++;
  endtask

  // One run of N layers; stall_pat[c] is stall_i sampled at start edge + c.
  // busy_wr_c: offset of a cfg write attempted while busy (-1 = none).
  // restart_drain: pulse start_i once during DRAIN.
  // same_wr: write entry (0,0) on the start edge.
  task automatic run_check(input int n, input int busy_wr_c, input bit restart_drain,
                           input bit same_wr, input logic [VEC_W-1:0] same_vec);
    int issue_c[$];
    int c_last, t_done, total, restart_c, k_iss, k_ov;
    for (int c = 0; c < PATN && issue_c.size() < 2*n; c++)
      if (stall_pat[c] == 0) issue_c.push_back(c);
    for (int c = PATN; issue_c.size() < 2*n; c++) issue_c.push_back(c);
    c_last    = issue_c[2*n-1];
    t_done    = c_last + 1 + LAT + 1;
    total     = t_done + 2;
    restart_c = restart_drain ? c_last + 2 : -1;
    if (same_wr) model_tab[0] = same_vec;

    start_i     = 1'b1;
    layer_num_i = (LW+1)'(n);
    stall_i     = stall_pat[0] != 0;
    if (same_wr) begin
      cfg_we_i    = 1'b1;
      cfg_layer_i = '0;
      cfg_src_i   = 1'b0;
      cfg_shift_i = same_vec;
    end
    for (int o = 1; o <= total; o++) begin
      tick();
      start_i  = 1'b0;
      cfg_we_i = 1'b0;
      k_iss = -1;
      k_ov  = -1;
      foreach (issue_c[i]) begin
        if (issue_c[i] + 1 == o)       k_iss = i;
        if (issue_c[i] + 1 + LAT == o) k_ov  = i;
      end
      if (k_iss >= 0) begin
        last_vec = model_tab[k_iss];
        last_src = k_iss[0];
      end
      total_cnt++;
      if (rd_en_o !== (k_iss >= 0))
        $display("FAIL rd_en o=%0d got %b exp %b", o, rd_en_o, k_iss >= 0);
      else pass_cnt++;
      total_cnt++;
      if (sw_in_src_o !== last_src)
        $display("FAIL sw_in_src o=%0d got %b exp %b", o, sw_in_src_o, last_src);
      else pass_cnt++;
      total_cnt++;
      if (shift_factor_o !== last_vec)
        $display("FAIL shift_factor o=%0d got %h exp %h", o, shift_factor_o, last_vec);
      else pass_cnt++;
      total_cnt++;
      if (out_valid_o !== (k_ov >= 0))
        $display("FAIL out_valid o=%0d got %b exp %b", o, out_valid_o, k_ov >= 0);
      else pass_cnt++;
      if (k_ov >= 0) begin
        total_cnt++;
        if ({out_layer_o, out_src_o} !== {LW'(k_ov / 2), k_ov[0]})
          $display("FAIL out_tag o=%0d got %0d/%0d exp %0d/%0d", o, out_layer_o, out_src_o,
                   k_ov / 2, k_ov % 2);
        else pass_cnt++;
      end
      total_cnt++;
      if (done_o !== (o == t_done))
        $display("FAIL done o=%0d got %b exp %b", o, done_o, o == t_done);
      else pass_cnt++;
      total_cnt++;
      if (busy_o !== (o <= t_done))
        $display("FAIL busy o=%0d got %b exp %b", o, busy_o, o <= t_done);
      else pass_cnt++;
      total_cnt++;
      if (cfg_err_o !== (busy_wr_c >= 0 && o == busy_wr_c + 1))
        $display("FAIL cfg_err_run o=%0d got %b exp %b", o, cfg_err_o,
                 busy_wr_c >= 0 && o == busy_wr_c + 1);
      else pass_cnt++;
      stall_i = (o < PATN) ? (stall_pat[o] != 0) : 1'b0;
      if (o == busy_wr_c) begin
        cfg_we_i    = 1'b1;
        cfg_layer_i = LW'($urandom_range(0, 3));
        cfg_src_i   = 1'($urandom_range(0, 1));
        cfg_shift_i = rand_vec();
      end
      if (o == restart_c) begin
        start_i     = 1'b1;
        layer_num_i = (LW+1)'(2);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({cfg_err_o, busy_o, done_o, rd_en_o, sw_in_src_o, out_valid_o, out_src_o} !== 7'b0)
      $display("FAIL reset_flags got %b exp 0",
               {cfg_err_o, busy_o, done_o, rd_en_o, sw_in_src_o, out_valid_o, out_src_o});
    else pass_cnt++;
    total_cnt++;
    if (shift_factor_o !== '0) $display("FAIL reset_shift got %h exp 0", shift_factor_o);
    else pass_cnt++;
    total_cnt++;
    if (out_layer_o !== '0) $display("FAIL reset_layer got %0d exp 0", out_layer_o);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_tab[i] = '0;
    last_vec = '0;
    last_src = 1'b0;
  endtask

  task automatic test_directed_n1();
    cfg_write(0, 1'b0, mk_vec(1, 2, 3, 4, 5));
    cfg_write(0, 1'b1, mk_vec(50, 0, 7, 8, 9));
    clear_stalls();
    run_check(1, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_full_n4();
    for (int k = 0; k < 8; k++) cfg_write(k / 2, k[0], rand_vec());
    clear_stalls();
    run_check(4, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_stall();
    clear_stalls();
    stall_pat[2] = 1;
    stall_pat[3] = 1;
    stall_pat[4] = 1;
    run_check(2, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_errors();
    int bad_num [2];
    bad_num[0] = 0;
    bad_num[1] = 5;
    cfg_write(1, 1'b0, mk_vec(1, 51, 3, 4, 5));
    cfg_write(2, 1'b1, mk_vec(63, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      start_i     = 1'b1;
      layer_num_i = (LW+1)'(bad_num[i]);
      tick();
      start_i = 1'b0;
      total_cnt++;
      if (cfg_err_o !== 1'b1)
        $display("FAIL start_err n=%0d got %b exp 1", bad_num[i], cfg_err_o);
      else pass_cnt++;
      total_cnt++;
      if ({busy_o, rd_en_o} !== 2'b00)
        $display("FAIL start_ignored n=%0d got %b exp 00", bad_num[i], {busy_o, rd_en_o});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({cfg_err_o, busy_o} !== 2'b00)
        $display("FAIL start_err_pulse n=%0d got %b exp 00", bad_num[i], {cfg_err_o, busy_o});
      else pass_cnt++;
    end
    clear_stalls();
    run_check(3, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_busy_write_and_drain_start();
    clear_stalls();
    run_check(2, 2, 1'b1, 1'b0, '0);
    run_check(4, -1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_same_cycle_write();
    clear_stalls();
    run_check(1, -1, 1'b0, 1'b1, rand_vec());
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++) cfg_write(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_vec());
      clear_stalls();
      for (int c = 1; c < 40; c++) stall_pat[c] = ($urandom_range(0, 9) < 3) ? 1 : 0;
      run_check(int'($urandom_range(1, 4)), -1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_run();
    stall_i     = 1'b0;
    start_i     = 1'b1;
    layer_num_i = (LW+1)'(4);
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy_o, done_o, rd_en_o, sw_in_src_o, out_valid_o, cfg_err_o} !== 6'b0)
      $display("FAIL midrst_flags got %b exp 0",
               {busy_o, done_o, rd_en_o, sw_in_src_o, out_valid_o, cfg_err_o});
    else pass_cnt++;
    total_cnt++;
    if (shift_factor_o !== '0) $display("FAIL midrst_shift got %h exp 0", shift_factor_o);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) model_tab[i] = '0;
    last_vec = '0;
    last_src = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total_cnt++;
      if ({done_o, out_valid_o, busy_o} !== 3'b000)
        $display("FAIL midrst_quiet i=%0d got %b exp 000", i, {done_o, out_valid_o, busy_o});
      else pass_cnt++;
    end
    clear_stalls();
    run_check(4, -1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_layer_i = '0;
    cfg_src_i   = 1'b0;
    cfg_shift_i = '0;
    start_i     = 1'b0;
    layer_num_i = '0;
    stall_i     = 1'b0;
    test_reset();
    test_directed_n1();
    test_full_n4();
    test_stall();
    test_errors();
    test_busy_write_and_drain_start();
    test_same_cycle_write();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
